// File: rtl/afg_dac_pkg.sv
// Shared constants and helpers for the DAC output path.
package afg_dac_pkg;

  localparam int DW = 12;
  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
  localparam int RATE_W = 16;

  // Occupancy counter width: one extra bit so a completely full FIFO is representable
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with extra-MSB pointers for full/empty disambiguation.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; the MSB toggles on each wrap so full and empty stay distinct
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dac_output_path.sv
// Paces buffered samples out to the DAC pins at a programmable rate through a fixed-latency pipeline.
module dac_output_path #(
  parameter int DW          = afg_dac_pkg::DW,
  parameter int FIFO_DEPTH  = 8,
  parameter int PIPE_STAGES = 4,
  parameter bit TWOS_COMP   = 1'b0,
  parameter bit UF_MIDSCALE = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [DW-1:0]                               din,
  input  logic                                        din_valid,
  output logic                                        din_ready,
  input  logic                                        enable,
  input  logic [afg_dac_pkg::RATE_W-1:0]              rate_div,
  input  logic                                        clear_flags,
  output logic [DW-1:0]                               dout,
  output logic                                        dac_wrt,
  output logic                                        underflow,
  output logic [afg_dac_pkg::level_w(FIFO_DEPTH)-1:0] level
);

  import afg_dac_pkg::*;

  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              tick;
  logic [DW-1:0]     stored;
  logic [DW-1:0]     head;
  logic [DW-1:0]     last_sample;
  logic [DW-1:0]     stage1_data;
  logic [RATE_W-1:0] cnt;
  logic [DW-1:0]     pipe_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_valid;

  // Ready comes from the registered full flag only, so a same-cycle pop never frees a slot for a push
  assign din_ready = ~full & ~reset;
  assign push      = din_valid & din_ready;
  assign stored    = TWOS_COMP ? {~din[DW-1], din[DW-2:0]} : din;
  assign tick      = enable && (cnt == rate_div);
  assign pop       = tick & ~empty;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (stored),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Underflow ticks still rewrite the DAC, with either the previous sample or midscale
  always_comb begin
    stage1_data = last_sample;
    if (pop)              stage1_data = head;
    else if (UF_MIDSCALE) stage1_data = MID;
  end

  // Rate divider; a count already past rate_div simply runs on and wraps
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  // Sticky underflow flag; a new underflow wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)               underflow <= 1'b0;
    else if (tick && empty)  underflow <= 1'b1;
    else if (clear_flags)    underflow <= 1'b0;
  end

  // Remember the most recent popped sample for the hold-last underflow policy
  always_ff @(posedge clk) begin
    if (reset)    last_sample <= MID;
    else if (pop) last_sample <= head;
  end

  // Fixed-length shift chain so latency never depends on the sample rate
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) pipe_data[i] <= MID;
    end else begin
      pipe_valid[0] <= tick;
      pipe_data[0]  <= stage1_data;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Output register: DAC data holds between writes, strobe marks each update
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= MID;
      dac_wrt <= 1'b0;
    end else begin
      dac_wrt <= pipe_valid[PIPE_STAGES-1];
      if (pipe_valid[PIPE_STAGES-1]) dout <= pipe_data[PIPE_STAGES-1];
    end
  end

endmodule

// File: tb/tb_dac_output_path.sv
// Self-checking bench for dac_output_path: default instance (a) and a two's-complement/midscale instance (b).
module tb_dac_output_path;

  localparam int P = 4;

  logic        clk;
  int          cyc;
  int          checks;
  int          errors;

  logic        a_reset, a_din_valid, a_enable, a_clear;
  logic [11:0] a_din;
  logic [15:0] a_rate_div;
  logic        a_din_ready, a_dac_wrt, a_underflow;
  logic [11:0] a_dout;
  logic [3:0]  a_level;

  logic        b_reset, b_din_valid, b_enable, b_clear;
  logic [11:0] b_din;
  logic [15:0] b_rate_div;
  logic        b_din_ready, b_dac_wrt, b_underflow;
  logic [11:0] b_dout;
  logic [3:0]  b_level;

  logic [11:0] qa[$];
  logic [11:0] qb[$];
  int          a_wr_cyc[$];
  int          b_wr_cyc[$];
  logic [11:0] exp_a;
  logic [11:0] exp_b;

  dac_output_path #(
    .DW(12), .FIFO_DEPTH(8), .PIPE_STAGES(P), .TWOS_COMP(1'b0), .UF_MIDSCALE(1'b0)
  ) dut_a (
    .clk(clk), .reset(a_reset), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .enable(a_enable), .rate_div(a_rate_div), .clear_flags(a_clear), .dout(a_dout),
    .dac_wrt(a_dac_wrt), .underflow(a_underflow), .level(a_level)
  );

  dac_output_path #(
    .DW(12), .FIFO_DEPTH(8), .PIPE_STAGES(P), .TWOS_COMP(1'b1), .UF_MIDSCALE(1'b1)
  ) dut_b (
    .clk(clk), .reset(b_reset), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .enable(b_enable), .rate_div(b_rate_div), .clear_flags(b_clear), .dout(b_dout),
    .dac_wrt(b_dac_wrt), .underflow(b_underflow), .level(b_level)
  );

  // Free-running clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard for instance a: every DAC write pops and compares one expected sample
  always @(negedge clk) begin
    if (a_dac_wrt === 1'b1) begin
      a_wr_cyc.push_back(cyc);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("[TB] FAIL a_unexpected_write: dout=%h, required no write", a_dout);
      end else begin
        exp_a = qa.pop_front();
        if (a_dout !== exp_a) begin
          errors++;
          $display("[TB] FAIL a_dout: got %h, expected %h", a_dout, exp_a);
        end
      end
    end
  end

  // Scoreboard for instance b
  always @(negedge clk) begin
    if (b_dac_wrt === 1'b1) begin
      b_wr_cyc.push_back(cyc);
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("[TB] FAIL b_unexpected_write: dout=%h, required no write", b_dout);
      end else begin
        exp_b = qb.pop_front();
        if (b_dout !== exp_b) begin
          errors++;
          $display("[TB] FAIL b_dout: got %h, expected %h", b_dout, exp_b);
        end
      end
    end
  end

  task automatic reset_a();
    a_reset = 1'b1; a_enable = 1'b0; a_din_valid = 1'b0; a_clear = 1'b0;
    repeat (2) @(negedge clk);
    a_reset = 1'b0;
    @(negedge clk);
    a_wr_cyc.delete();
  endtask

  task automatic reset_b();
    b_reset = 1'b1; b_enable = 1'b0; b_din_valid = 1'b0; b_clear = 1'b0;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    @(negedge clk);
    b_wr_cyc.delete();
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_din = '0; a_din_valid = 1'b0; a_enable = 1'b0; a_rate_div = '0; a_clear = 1'b0;
    b_reset = 1'b1; b_din = '0; b_din_valid = 1'b0; b_enable = 1'b0; b_rate_div = '0; b_clear = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_reset: got %b, expected 0", a_din_ready); end
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_dout !== 12'h800) begin errors++; $display("[TB] FAIL reset_dout: got %h, expected 800", a_dout); end
    checks++;
    if (a_dac_wrt !== 1'b0) begin errors++; $display("[TB] FAIL reset_dac_wrt: got %b, expected 0", a_dac_wrt); end
    checks++;
    if (a_din_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", a_din_ready); end
    checks++;
    if (a_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, expected 0", a_level); end
    checks++;
    if (a_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow: got %b, expected 0", a_underflow); end
    checks++;
    if (b_dout !== 12'h800) begin errors++; $display("[TB] FAIL reset_b_dout: got %h, expected 800", b_dout); end
  endtask

  task automatic test_back_to_back();
    int e0;
    reset_a();
    a_rate_div = 16'd0;
    qa.push_back(12'h001); qa.push_back(12'h002); qa.push_back(12'h003);
    qa.push_back(12'h004); qa.push_back(12'h004);
    a_din = 12'h001; a_din_valid = 1'b1; a_enable = 1'b0;
    @(negedge clk);
    e0 = cyc;
    checks++;
    if (a_level !== 4'd1) begin errors++; $display("[TB] FAIL b2b_level1: got %0d, expected 1", a_level); end
    a_din = 12'h002; a_enable = 1'b1;
    @(negedge clk);
    a_din = 12'h003;
    @(negedge clk);
    a_din = 12'h004;
    @(negedge clk);
    a_din_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_level !== 4'd0) begin errors++; $display("[TB] FAIL b2b_drained: got %0d, expected 0", a_level); end
    @(negedge clk);
    checks++;
    if (a_underflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_underflow: got %b, expected 1", a_underflow); end
    a_enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (a_wr_cyc.size() != 5) begin
      errors++; $display("[TB] FAIL b2b_write_count: got %0d, expected 5", a_wr_cyc.size());
    end else begin
      checks++;
      if (a_wr_cyc[0] != e0 + 1 + P) begin errors++; $display("[TB] FAIL b2b_latency: got cycle %0d, expected %0d", a_wr_cyc[0], e0 + 1 + P); end
      checks++;
      if (a_wr_cyc[4] - a_wr_cyc[0] != 4) begin errors++; $display("[TB] FAIL b2b_consecutive: got span %0d, expected 4", a_wr_cyc[4] - a_wr_cyc[0]); end
    end
    checks++;
    if (a_dout !== 12'h004) begin errors++; $display("[TB] FAIL b2b_hold: got %h, expected 004", a_dout); end
    checks++;
    if (qa.size() != 0) begin errors++; $display("[TB] FAIL b2b_pending: got %0d left, expected 0", qa.size()); qa.delete(); end
  endtask

  task automatic test_rate();
    int e1;
    reset_a();
    a_rate_div = 16'd9;
    for (int i = 0; i < 5; i++) begin
      a_din = 12'h100 + 12'(i); a_din_valid = 1'b1;
      @(negedge clk);
    end
    a_din_valid = 1'b0;
    checks++;
    if (a_level !== 4'd5) begin errors++; $display("[TB] FAIL rate_prefill: got %0d, expected 5", a_level); end
    qa.push_back(12'h100); qa.push_back(12'h101); qa.push_back(12'h102);
    a_enable = 1'b1;
    @(negedge clk);
    e1 = cyc;
    for (int k = 0; k < 60; k++) begin
      if (a_enable && a_level == 4'd2) a_enable = 1'b0;
      @(negedge clk);
    end
    a_enable = 1'b0;
    checks++;
    if (a_wr_cyc.size() != 3) begin
      errors++; $display("[TB] FAIL rate_write_count: got %0d, expected 3", a_wr_cyc.size());
    end else begin
      checks++;
      if (a_wr_cyc[0] != e1 + 9 + P) begin errors++; $display("[TB] FAIL rate_first: got cycle %0d, expected %0d", a_wr_cyc[0], e1 + 9 + P); end
      checks++;
      if (a_wr_cyc[1] - a_wr_cyc[0] != 10) begin errors++; $display("[TB] FAIL rate_period1: got %0d, expected 10", a_wr_cyc[1] - a_wr_cyc[0]); end
      checks++;
      if (a_wr_cyc[2] - a_wr_cyc[1] != 10) begin errors++; $display("[TB] FAIL rate_period2: got %0d, expected 10", a_wr_cyc[2] - a_wr_cyc[1]); end
    end
    checks++;
    if (a_level !== 4'd2) begin errors++; $display("[TB] FAIL rate_retained: got %0d, expected 2", a_level); end
    checks++;
    if (a_dout !== 12'h102) begin errors++; $display("[TB] FAIL rate_hold: got %h, expected 102", a_dout); end
    checks++;
    if (a_underflow !== 1'b0) begin errors++; $display("[TB] FAIL rate_underflow: got %b, expected 0", a_underflow); end
    checks++;
    if (qa.size() != 0) begin errors++; $display("[TB] FAIL rate_pending: got %0d left, expected 0", qa.size()); qa.delete(); end
  endtask

  task automatic test_full();
    reset_a();
    a_rate_div = 16'd0;
    for (int i = 0; i < 8; i++) begin
      a_din = 12'h200 + 12'(i); a_din_valid = 1'b1;
      checks++;
      if (a_din_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_%0d: got %b, expected 1", i, a_din_ready); end
      @(negedge clk);
    end
    a_din = 12'h208;
    checks++;
    if (a_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_low: got %b, expected 0", a_din_ready); end
    checks++;
    if (a_level !== 4'd8) begin errors++; $display("[TB] FAIL full_level: got %0d, expected 8", a_level); end
    @(negedge clk);
    checks++;
    if (a_level !== 4'd8) begin errors++; $display("[TB] FAIL full_ninth_held: got %0d, expected 8", a_level); end
    for (int i = 0; i < 9; i++) qa.push_back(12'h200 + 12'(i));
    a_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (a_level !== 4'd7) begin errors++; $display("[TB] FAIL full_first_pop: got %0d, expected 7", a_level); end
    checks++;
    if (a_din_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_after_pop: got %b, expected 1", a_din_ready); end
    @(negedge clk);
    a_din_valid = 1'b0;
    checks++;
    if (a_level !== 4'd7) begin errors++; $display("[TB] FAIL full_push_pop: got %0d, expected 7", a_level); end
    for (int k = 0; k < 30; k++) begin
      if (a_enable && a_level == 4'd0) a_enable = 1'b0;
      @(negedge clk);
    end
    a_enable = 1'b0;
    checks++;
    if (a_wr_cyc.size() != 9) begin errors++; $display("[TB] FAIL full_write_count: got %0d, expected 9", a_wr_cyc.size()); end
    checks++;
    if (a_underflow !== 1'b0) begin errors++; $display("[TB] FAIL full_underflow: got %b, expected 0", a_underflow); end
    checks++;
    if (qa.size() != 0) begin errors++; $display("[TB] FAIL full_pending: got %0d left, expected 0", qa.size()); qa.delete(); end
  endtask

  task automatic test_underflow_midscale();
    reset_b();
    b_rate_div = 16'd0;
    b_din = 12'h123; b_din_valid = 1'b1;
    @(negedge clk);
    b_din_valid = 1'b0;
    qb.push_back(12'h923); qb.push_back(12'h800);
    b_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (b_underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_early: got %b, expected 0", b_underflow); end
    @(negedge clk);
    b_enable = 1'b0;
    checks++;
    if (b_underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_set: got %b, expected 1", b_underflow); end
    repeat (P + 3) @(negedge clk);
    checks++;
    if (b_wr_cyc.size() != 2) begin errors++; $display("[TB] FAIL uf_write_count: got %0d, expected 2", b_wr_cyc.size()); end
    checks++;
    if (b_dout !== 12'h800) begin errors++; $display("[TB] FAIL uf_midscale: got %h, expected 800", b_dout); end
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
    checks++;
    if (b_underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear: got %b, expected 0", b_underflow); end
    qb.push_back(12'h800);
    b_enable = 1'b1; b_clear = 1'b1;
    @(negedge clk);
    b_enable = 1'b0; b_clear = 1'b0;
    checks++;
    if (b_underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_set_over_clear: got %b, expected 1", b_underflow); end
    repeat (P + 3) @(negedge clk);
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
    checks++;
    if (b_underflow !== 1'b0) begin errors++; $display("[TB] FAIL uf_clear2: got %b, expected 0", b_underflow); end
    checks++;
    if (qb.size() != 0) begin errors++; $display("[TB] FAIL uf_pending: got %0d left, expected 0", qb.size()); qb.delete(); end
  endtask

  task automatic test_twos_comp();
    reset_b();
    b_rate_div = 16'd0;
    b_din = 12'h800; b_din_valid = 1'b1;
    @(negedge clk);
    b_din = 12'h7FF;
    @(negedge clk);
    b_din_valid = 1'b0;
    qb.push_back(12'h000); qb.push_back(12'hFFF);
    b_enable = 1'b1;
    repeat (2) @(negedge clk);
    b_enable = 1'b0;
    repeat (P + 3) @(negedge clk);
    checks++;
    if (b_dout !== 12'hFFF) begin errors++; $display("[TB] FAIL tc_last: got %h, expected fff", b_dout); end
    checks++;
    if (b_wr_cyc.size() != 2) begin errors++; $display("[TB] FAIL tc_write_count: got %0d, expected 2", b_wr_cyc.size()); end
    for (int i = 1; i <= 3; i++) begin
      b_din = 12'(i); b_din_valid = 1'b1;
      @(negedge clk);
    end
    b_din_valid = 1'b0;
    b_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (b_level !== 4'd2) begin errors++; $display("[TB] FAIL tc_midstream_level: got %0d, expected 2", b_level); end
    b_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (b_dout !== 12'h800) begin errors++; $display("[TB] FAIL tc_reset_dout: got %h, expected 800", b_dout); end
    checks++;
    if (b_level !== 4'd0) begin errors++; $display("[TB] FAIL tc_reset_level: got %0d, expected 0", b_level); end
    checks++;
    if (b_din_ready !== 1'b0) begin errors++; $display("[TB] FAIL tc_reset_ready: got %b, expected 0", b_din_ready); end
    b_reset = 1'b0; b_enable = 1'b0;
    repeat (P + 3) @(negedge clk);
    checks++;
    if (b_wr_cyc.size() != 2) begin errors++; $display("[TB] FAIL tc_flushed: got %0d writes, expected 2", b_wr_cyc.size()); end
    checks++;
    if (b_dout !== 12'h800) begin errors++; $display("[TB] FAIL tc_after_reset: got %h, expected 800", b_dout); end
    checks++;
    if (qb.size() != 0) begin errors++; $display("[TB] FAIL tc_pending: got %0d left, expected 0", qb.size()); qb.delete(); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_back_to_back();
    test_rate();
    test_full();
    test_underflow_midscale();
    test_twos_comp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
